// File: rtl/convolution_3x3.sv
// 3x3 Gaussian-style streaming convolution (kernel [1 2 1; 2 4 2; 1 2 1] / 16) over a row-major pixel stream.
// Optional macro CONV_ROUND_EN selects round-half-up instead of truncation for the final divide.
module convolution_3x3 #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ROW_SIZE  = 540
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic [1:0]           valid
);

    localparam int unsigned COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int unsigned SUM_W = WORD_SIZE + 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);

    localparam logic [1:0] VALID_PRIME = 2'b00;
    localparam logic [1:0] VALID_OK    = 2'b01;
    localparam logic [1:0] VALID_WRAP  = 2'b10;

    logic [COL_W-1:0]     r_col;
    logic [1:0]           r_row;
    logic [WORD_SIZE-1:0] r_lb_top [ROW_SIZE];
    logic [WORD_SIZE-1:0] r_lb_mid [ROW_SIZE];
    logic [WORD_SIZE-1:0] r_win_c2 [3];
    logic [WORD_SIZE-1:0] r_win_c1 [3];

    logic [WORD_SIZE-1:0] w_col [3];
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_sum_adj;
    logic [WORD_SIZE-1:0] w_result;

    // Newest window column: rows r-2, r-1 from the line buffers, row r from the input.
    always_comb begin
        w_col[0] = r_lb_top[r_col];
        w_col[1] = r_lb_mid[r_col];
        w_col[2] = inputPixel;
    end

    always_comb begin
        w_sum = SUM_W'(r_win_c2[0])        + (SUM_W'(r_win_c1[0]) << 1) + SUM_W'(w_col[0])
              + (SUM_W'(r_win_c2[1]) << 1) + (SUM_W'(r_win_c1[1]) << 2) + (SUM_W'(w_col[1]) << 1)
              + SUM_W'(r_win_c2[2])        + (SUM_W'(r_win_c1[2]) << 1) + SUM_W'(w_col[2]);
`ifdef CONV_ROUND_EN
        w_sum_adj = w_sum + SUM_W'(8);
`else
        w_sum_adj = w_sum;
`endif
        w_result = w_sum_adj[SUM_W-1:4];
    end

    // Line buffers and window carry no reset; row/column gating keeps stale data out of valid results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lb_top[r_col] <= r_lb_mid[r_col];
            r_lb_mid[r_col] <= inputPixel;
            for (int i = 0; i < 3; i++) begin
                r_win_c2[i] <= r_win_c1[i];
                r_win_c1[i] <= w_col[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            outputPixel <= '0;
            valid       <= VALID_PRIME;
        end else begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row != 2'd2) begin
                    r_row <= r_row + 2'd1;
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end

            if (r_row != 2'd2) begin
                outputPixel <= '0;
                valid       <= VALID_PRIME;
            end else if (r_col >= COL_W'(2)) begin
                outputPixel <= w_result;
                valid       <= VALID_OK;
            end else begin
                outputPixel <= '0;
                valid       <= VALID_WRAP;
            end
        end
    end

endmodule

// File: tb/tb_convolution_3x3.sv
// Directed self-checking bench for convolution_3x3 with a 4-pixel row.
module tb_convolution_3x3;

    localparam int unsigned RS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] inputPixel = 8'h00;
    logic [7:0] outputPixel;
    logic [1:0] valid;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CONV_ROUND_EN
    localparam logic [7:0] SMALL_EXP = 8'h01;
`else
    localparam logic [7:0] SMALL_EXP = 8'h00;
`endif

    convolution_3x3 #(.WORD_SIZE(8), .ROW_SIZE(RS)) dut (
        .clk        (clk),
        .rst        (rst),
        .inputPixel (inputPixel),
        .outputPixel(outputPixel),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] pix);
        inputPixel = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inputPixel = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (outputPixel !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_out: got %h expected 00", outputPixel);
        end
        n_checks++;
        if (valid !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_valid: got %b expected 00", valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_constant();
        logic [1:0] ev;
        logic [7:0] eo;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step(8'h40);
            if (n < 2 * RS) begin
                ev = 2'b00; eo = 8'h00;
            end else if ((n % RS) < 2) begin
                ev = 2'b10; eo = 8'h00;
            end else begin
                ev = 2'b01; eo = 8'h40;
            end
            n_checks++;
            if (valid !== ev || outputPixel !== eo) begin
                n_errors++;
                $display("FAIL const_n%0d: got valid=%b out=%h expected valid=%b out=%h",
                         n, valid, outputPixel, ev, eo);
            end
        end
    endtask

    task automatic test_impulse();
        logic [7:0] eo;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step((n == 5) ? 8'h10 : 8'h00);
            if (n == 10 || n == 11 || n == 14 || n == 15) begin
                eo = (n == 10) ? 8'h04 : (n == 15) ? 8'h01 : 8'h02;
                n_checks++;
                if (valid !== 2'b01 || outputPixel !== eo) begin
                    n_errors++;
                    $display("FAIL impulse_n%0d: got valid=%b out=%h expected valid=01 out=%h",
                             n, valid, outputPixel, eo);
                end
            end
        end
    endtask

    task automatic test_round();
        do_reset();
        for (int n = 0; n < 11; n++) begin
            step((n == 5) ? 8'h02 : 8'h00);
        end
        n_checks++;
        if (valid !== 2'b01 || outputPixel !== SMALL_EXP) begin
            n_errors++;
            $display("FAIL round_centre: got valid=%b out=%h expected valid=01 out=%h",
                     valid, outputPixel, SMALL_EXP);
        end
    endtask

    task automatic test_long_stream();
        int c01 = 0;
        int c10 = 0;
        int bad = 0;
        do_reset();
        for (int n = 0; n < 6 * RS; n++) begin
            step(8'hFF);
            if (valid == 2'b01) begin
                c01++;
                if (outputPixel !== 8'hFF) bad++;
            end else if (valid == 2'b10) begin
                c10++;
            end else if (valid !== 2'b00) begin
                bad++;
            end
        end
        n_checks++;
        if (c01 != 8) begin
            n_errors++;
            $display("FAIL long_count01: got %0d expected 8", c01);
        end
        n_checks++;
        if (c10 != 8) begin
            n_errors++;
            $display("FAIL long_count10: got %0d expected 8", c10);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL long_values: got %0d bad samples expected 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int first = -1;
        do_reset();
        for (int n = 0; n < 14; n++) begin
            step(8'hFF);
        end
        rst = 1'b1;
        step(8'h77);
        rst = 1'b0;
        n_checks++;
        if (valid !== 2'b00 || outputPixel !== 8'h00) begin
            n_errors++;
            $display("FAIL midrst_state: got valid=%b out=%h expected valid=00 out=00",
                     valid, outputPixel);
        end
        for (int k = 0; k < 16; k++) begin
            step(8'h20);
            if (first < 0 && valid == 2'b01) begin
                first = k;
                n_checks++;
                if (outputPixel !== 8'h20) begin
                    n_errors++;
                    $display("FAIL midrst_value: got %h expected 20", outputPixel);
                end
            end
        end
        n_checks++;
        if (first != 2 * RS + 2) begin
            n_errors++;
            $display("FAIL midrst_prime: got first valid at %0d expected %0d", first, 2 * RS + 2);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_round();
        test_long_stream();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
